// File: rtl/crypto_frame_packer_pkg.sv
// Shared types and constants for the crypto frame packer and its consumers.
// The header-beat packing helper is reused by downstream crypto benches.
package crypto_frame_packer_pkg;

    localparam int unsigned CFP_DATA_WIDTH  = 128;
    localparam int unsigned CFP_NONCE_WIDTH = 96;
    localparam logic [31:0] CFP_CTR_INIT    = 32'h0000_0001;

    typedef enum logic [2:0] {
        StIdle,
        StKey,
        StHdr,
        StPayload,
        StLastWait,
        StDrop
    } cfp_state_e;

    function automatic logic [127:0] pack_hdr(input logic [95:0] nonce, input logic [31:0] ctr);
        return {nonce, ctr};
    endfunction

endpackage

// File: rtl/crypto_frame_packer_axis_out_reg.sv
// Single-entry registered AXI-Stream output stage. Accepts a new beat whenever
// it is empty or its current beat is draining; holds the beat stable while stalled.
module crypto_frame_packer_axis_out_reg #(
    parameter int unsigned W = 128
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_last,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_last,
    input  logic         i_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_last;
    logic         w_ready;

    assign w_ready = !r_valid || i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_valid && w_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/crypto_frame_packer.sv
// Builds crypto frames (key beat, header beat, payload) and sequences the nonce.
// Optional payload-length limit with truncation/drop is enabled by MAX_BEATS_EN.
module crypto_frame_packer
    import crypto_frame_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = CFP_DATA_WIDTH,
    parameter int unsigned NONCE_WIDTH = CFP_NONCE_WIDTH,
    parameter logic [31:0] CTR_INIT    = CFP_CTR_INIT
`ifdef MAX_BEATS_EN
    ,
    parameter int unsigned MAX_BEATS   = 256
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  cfg_key,
    input  logic [NONCE_WIDTH-1:0] cfg_nonce,
    input  logic                   cfg_load,
    output logic                   S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0]  S_AXIS_TDATA,
    input  logic                   S_AXIS_TLAST,
    input  logic                   S_AXIS_TVALID,
    output logic                   M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0]  M_AXIS_TDATA,
    output logic                   M_AXIS_TLAST,
    input  logic                   M_AXIS_TREADY,
    output logic [31:0]            frame_count,
    output logic                   nonce_wrap,
    output logic                   busy
`ifdef MAX_BEATS_EN
    ,
    output logic                   trunc_err
`endif
);

    cfp_state_e               r_state;
    logic [NONCE_WIDTH-1:0]   r_nonce;
    logic [NONCE_WIDTH-1:0]   r_pend_nonce;
    logic                     r_pend;
    logic [31:0]              r_frame_count;
    logic                     r_nonce_wrap;

    logic                     w_m_valid;
    logic [DATA_WIDTH-1:0]    w_m_data;
    logic                     w_m_last;
    logic                     w_stage_ready;
    logic                     w_ld_valid;
    logic [DATA_WIDTH-1:0]    w_ld_data;
    logic                     w_ld_last;
    logic                     w_m_hs;
    logic                     w_s_ready;
    logic                     w_s_hs;
    logic                     w_force_last;
    logic [NONCE_WIDTH:0]     w_nonce_inc;

`ifdef MAX_BEATS_EN
    localparam int unsigned BEAT_W = $clog2(MAX_BEATS) + 1;
    logic [BEAT_W-1:0] r_beats;
    logic              r_drop;
    logic              r_trunc_err;
    assign w_force_last = (r_beats == BEAT_W'(MAX_BEATS - 1));
    assign trunc_err    = r_trunc_err;
`else
    assign w_force_last = 1'b0;
`endif

    assign w_m_hs      = w_m_valid && M_AXIS_TREADY;
    assign w_s_ready   = ((r_state == StPayload) && w_stage_ready) || (r_state == StDrop);
    assign w_s_hs      = S_AXIS_TVALID && w_s_ready;
    assign w_nonce_inc = {1'b0, r_nonce} + (NONCE_WIDTH + 1)'(1);

    // Next beat offered to the output stage; the stage is always empty in IDLE.
    always_comb begin
        w_ld_valid = 1'b0;
        w_ld_data  = '0;
        w_ld_last  = 1'b0;
        case (r_state)
            StIdle: begin
                w_ld_valid = S_AXIS_TVALID;
                w_ld_data  = cfg_key;
            end
            StKey: begin
                w_ld_valid = w_m_hs;
                w_ld_data  = pack_hdr(r_nonce, CTR_INIT);
            end
            StPayload: begin
                w_ld_valid = w_s_hs;
                w_ld_data  = S_AXIS_TDATA;
                w_ld_last  = S_AXIS_TLAST || w_force_last;
            end
            default: ;
        endcase
    end

    crypto_frame_packer_axis_out_reg #(
        .W(DATA_WIDTH)
    ) u_out_reg (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (w_ld_valid),
        .i_data  (w_ld_data),
        .i_last  (w_ld_last),
        .o_ready (w_stage_ready),
        .o_valid (w_m_valid),
        .o_data  (w_m_data),
        .o_last  (w_m_last),
        .i_ready (M_AXIS_TREADY)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_nonce       <= '0;
            r_pend_nonce  <= '0;
            r_pend        <= 1'b0;
            r_frame_count <= '0;
            r_nonce_wrap  <= 1'b0;
`ifdef MAX_BEATS_EN
            r_beats       <= '0;
            r_drop        <= 1'b0;
            r_trunc_err   <= 1'b0;
`endif
        end else begin
`ifdef MAX_BEATS_EN
            r_trunc_err <= 1'b0;
`endif
            if (cfg_load && (r_state != StIdle)) begin
                r_pend       <= 1'b1;
                r_pend_nonce <= cfg_nonce;
            end
            case (r_state)
                StIdle: begin
                    if (cfg_load) r_nonce <= cfg_nonce;
                    if (S_AXIS_TVALID) r_state <= StKey;
`ifdef MAX_BEATS_EN
                    r_beats <= '0;
`endif
                end
                StKey: if (w_m_hs) r_state <= StHdr;
                StHdr: if (w_m_hs) r_state <= StPayload;
                StPayload: begin
                    if (w_s_hs) begin
                        if (S_AXIS_TLAST) begin
                            r_state <= StLastWait;
`ifdef MAX_BEATS_EN
                        end else if (w_force_last) begin
                            r_state     <= StLastWait;
                            r_drop      <= 1'b1;
                            r_trunc_err <= 1'b1;
`endif
                        end
`ifdef MAX_BEATS_EN
                        r_beats <= r_beats + BEAT_W'(1);
`endif
                    end
                end
                StLastWait: begin
                    if (w_m_hs) begin
                        r_frame_count <= r_frame_count + 32'd1;
                        r_pend        <= 1'b0;
                        // A pending load overrides the per-frame increment.
                        if (cfg_load) begin
                            r_nonce <= cfg_nonce;
                        end else if (r_pend) begin
                            r_nonce <= r_pend_nonce;
                        end else begin
                            r_nonce <= w_nonce_inc[NONCE_WIDTH-1:0];
                            if (w_nonce_inc[NONCE_WIDTH]) r_nonce_wrap <= 1'b1;
                        end
`ifdef MAX_BEATS_EN
                        r_state <= r_drop ? StDrop : StIdle;
                        r_drop  <= 1'b0;
`else
                        r_state <= StIdle;
`endif
                    end
                end
`ifdef MAX_BEATS_EN
                StDrop: begin
                    if (w_s_hs && S_AXIS_TLAST) begin
                        r_state <= StIdle;
                        r_pend  <= 1'b0;
                        if (cfg_load) begin
                            r_nonce <= cfg_nonce;
                        end else if (r_pend) begin
                            r_nonce <= r_pend_nonce;
                        end
                    end
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

    assign S_AXIS_TREADY = w_s_ready;
    assign M_AXIS_TVALID = w_m_valid;
    assign M_AXIS_TDATA  = w_m_data;
    assign M_AXIS_TLAST  = w_m_last;
    assign frame_count   = r_frame_count;
    assign nonce_wrap    = r_nonce_wrap;
    assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_crypto_frame_packer.sv
// Scoreboard bench for crypto_frame_packer: a frame-level model queues expected
// output beats and a negedge monitor compares every M-side handshake.
module tb_crypto_frame_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] cfg_key = '0;
    logic [95:0]  cfg_nonce = '0;
    logic         cfg_load = 1'b0;
    logic         S_AXIS_TREADY;
    logic [127:0] S_AXIS_TDATA = '0;
    logic         S_AXIS_TLAST = 1'b0;
    logic         S_AXIS_TVALID = 1'b0;
    logic         M_AXIS_TVALID;
    logic [127:0] M_AXIS_TDATA;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TREADY = 1'b1;
    logic [31:0]  frame_count;
    logic         nonce_wrap;
    logic         busy;

`ifdef MAX_BEATS_EN
    localparam int TB_MAX = 2;
    logic trunc_err;
    int   trunc_seen = 0;
    int   m_trunc = 0;
    crypto_frame_packer #(.MAX_BEATS(TB_MAX)) dut (
`else
    localparam int TB_MAX = 1 << 30;
    crypto_frame_packer dut (
`endif
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_key       (cfg_key),
        .cfg_nonce     (cfg_nonce),
        .cfg_load      (cfg_load),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .frame_count   (frame_count),
        .nonce_wrap    (nonce_wrap),
`ifdef MAX_BEATS_EN
        .busy          (busy),
        .trunc_err     (trunc_err)
`else
        .busy          (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] d;
        logic         l;
    } beat_t;

    beat_t        sb[$];
    logic [127:0] fix_q[$];
    int           checks = 0;
    int           errors = 0;
    int           rdy_mode = 0;

    // Frame-level reference state
    logic [95:0]  m_nonce = '0;
    logic [31:0]  m_fc = '0;
    logic         m_wrap = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Downstream ready patterns: always, 1-0-0-1, random
    initial begin
        int idx = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: M_AXIS_TREADY = 1'b1;
                1: begin
                    M_AXIS_TREADY = (idx % 4 == 0) || (idx % 4 == 3);
                    idx++;
                end
                default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pop, hold-while-stalled and input-ready rules
    initial begin
        logic         prev_stall = 1'b0;
        logic [127:0] prev_d = '0;
        logic         prev_l = 1'b0;
        beat_t        e;
        forever begin
            @(negedge clk);
`ifdef MAX_BEATS_EN
            if (trunc_err === 1'b1) trunc_seen++;
`endif
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {127'b0, M_AXIS_TVALID}, 128'd1);
                    chk("stall_data", M_AXIS_TDATA, prev_d);
                    chk("stall_last", {127'b0, M_AXIS_TLAST}, {127'b0, prev_l});
                end
                if (M_AXIS_TVALID && !M_AXIS_TREADY && S_AXIS_TREADY) begin
                    checks++;
                    errors++;
                    $display("FAIL s_ready_full: got 1 expected 0");
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h expected none", M_AXIS_TDATA);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_data", M_AXIS_TDATA, e.d);
                        chk("beat_last", {127'b0, M_AXIS_TLAST}, {127'b0, e.l});
                    end
                end
                prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
                prev_d     = M_AXIS_TDATA;
                prev_l     = M_AXIS_TLAST;
            end
        end
    end

    task automatic pulse_load(input logic [95:0] v);
        @(posedge clk);
        #1;
        cfg_nonce = v;
        cfg_load  = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        m_nonce  = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, {127'b0, M_AXIS_TVALID}, '0);
        chk({tag, "_m_data"}, M_AXIS_TDATA, '0);
        chk({tag, "_m_last"}, {127'b0, M_AXIS_TLAST}, '0);
        chk({tag, "_s_ready"}, {127'b0, S_AXIS_TREADY}, '0);
        chk({tag, "_frame_count"}, {96'b0, frame_count}, '0);
        chk({tag, "_nonce_wrap"}, {127'b0, nonce_wrap}, '0);
        chk({tag, "_busy"}, {127'b0, busy}, '0);
    endtask

    // Sends one payload frame; optional mid-frame cfg_load and reset abort.
    task automatic send_frame(input logic [127:0] key, input int n, input bit load_mid,
                              input logic [95:0] mid_val, input int abort_after);
        logic [127:0] d[$];
        logic [96:0]  inc;
        int           emit;
        int           cnt;
        bit           acc;
        for (int i = 0; i < n; i++) begin
            if (fix_q.size() != 0) d.push_back(fix_q.pop_front());
            else d.push_back({$urandom, $urandom, $urandom, $urandom});
        end
        emit = (n > TB_MAX) ? TB_MAX : n;
        sb.push_back('{d: key, l: 1'b0});
        sb.push_back('{d: {m_nonce, 32'h0000_0001}, l: 1'b0});
        for (int i = 0; i < emit; i++) sb.push_back('{d: d[i], l: (i == emit - 1)});
`ifdef MAX_BEATS_EN
        if (n > TB_MAX && (abort_after == 0 || abort_after >= TB_MAX)) m_trunc++;
`endif
        @(posedge clk);
        #1;
        cfg_key = key;
        for (int i = 0; i < n; i++) begin
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = d[i];
            S_AXIS_TLAST  = (i == n - 1);
            cnt = 0;
            do begin
                @(negedge clk);
                acc = S_AXIS_TREADY;
                @(posedge clk);
                #1;
                cfg_load = 1'b0;
                cnt++;
            end while (!acc && cnt < 500);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL s_accept_timeout: got no handshake expected beat %0d", i);
                S_AXIS_TVALID = 1'b0;
                return;
            end
            // Key changes after frame start must not affect this frame
            cfg_key = {$urandom, $urandom, $urandom, $urandom};
            if (load_mid && i == 0) begin
                cfg_nonce = mid_val;
                cfg_load  = 1'b1;
            end
            if (abort_after > 0 && i + 1 == abort_after) begin
                S_AXIS_TVALID = 1'b0;
                S_AXIS_TLAST  = 1'b0;
                cfg_load      = 1'b0;
                rst_n         = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                check_reset_outputs("abort");
                sb.delete();
                m_nonce = '0;
                m_fc    = '0;
                m_wrap  = 1'b0;
                return;
            end
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        m_fc++;
        if (load_mid) begin
            m_nonce = mid_val;
        end else begin
            inc     = {1'b0, m_nonce} + 97'd1;
            m_nonce = inc[95:0];
            if (inc[96]) m_wrap = 1'b1;
        end
        cnt = 0;
        while ((sb.size() != 0 || busy) && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 2000) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: got %0d beats left expected 0", sb.size());
        end
        chk("frame_count", {96'b0, frame_count}, {96'b0, m_fc});
        chk("nonce_wrap", {127'b0, nonce_wrap}, {127'b0, m_wrap});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame
        pulse_load(96'h13360015f2cb949b8fb0013e);
        fix_q.push_back(128'h4df64bff1fa11895af337eb66b66e129);
        fix_q.push_back(128'h0000000000000000000000_1fda3cf888);
        send_frame(128'hee84e19cda87a76291eaaf2054aef812, 2, 1'b0, '0, 0);

        // Back-to-back, nonce increments
        send_frame(128'ha3557da8c75e9dfde2ff0bd90d0156f8, 4, 1'b0, '0, 0);

        // Backpressure 1,0,0,1
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) begin
            send_frame({$urandom, $urandom, $urandom, $urandom}, 1 + f * 2, 1'b0, '0, 0);
        end

        // Nonce wrap with single-beat frames
        rdy_mode = 0;
        pulse_load(96'hffffffffffffffffffffffff);
        send_frame({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, '0, 0);
        send_frame({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, '0, 0);

        // cfg_load while busy
        send_frame({$urandom, $urandom, $urandom, $urandom}, 3, 1'b1,
                   96'h000000000000000000000abc, 0);
        send_frame({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, '0, 0);

        // Random traffic
        rdy_mode = 2;
        for (int f = 0; f < 10; f++) begin
            send_frame({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 6),
                       1'b0, '0, 0);
        end

        // Reset mid-payload, then restart from nonce 0
        rdy_mode = 0;
        send_frame({$urandom, $urandom, $urandom, $urandom}, 5, 1'b0, '0, 2);
        send_frame({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, '0, 0);

`ifdef MAX_BEATS_EN
        repeat (3) @(posedge clk);
        chk("trunc_pulses", 128'(trunc_seen), 128'(m_trunc));
`endif
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
